// File: rtl/l2c_mem_emu_mp.sv
// l2c_mem_emu_mp: multi-port memory emulator that stands in for the L2 cache.
// Request ports are arbitrated round-robin into one word-wide array. Each
// granted access travels down a fixed-latency pipeline into a shared answer
// FIFO. A credit counter holds the number of in-flight requests, which keeps
// the FIFO from overflowing. A free-running counter produces the dump strobe.
module l2c_mem_emu_mp #(
  parameter int NumPorts   = 2,
  parameter int AddrW      = 32,
  parameter int DataW      = 64,
  parameter int IdW        = 4,
  parameter int MemWords   = 1024,
  parameter int Latency    = 4,
  parameter int RespDepth  = 4,
  parameter int DumpPeriod = 20,
  localparam int PortW     = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic [NumPorts-1:0]       req_valid_i,
  output logic [NumPorts-1:0]       req_ready_o,
  input  logic [NumPorts-1:0]       req_we_i,
  input  logic [NumPorts*AddrW-1:0] req_addr_i,
  input  logic [NumPorts*DataW-1:0] req_wdata_i,
  input  logic [NumPorts*IdW-1:0]   req_id_i,
  output logic                      ans_valid_o,
  input  logic                      ans_ready_i,
  output logic [DataW-1:0]          ans_data_o,
  output logic [PortW-1:0]          ans_port_o,
  output logic [IdW-1:0]            ans_id_o,
  output logic                      ans_err_o,
  output logic                      busy_o,
  output logic                      dump_tick_o
);

  localparam int OffW   = $clog2(DataW / 8);
  localparam int IdxW   = (MemWords > 1) ? $clog2(MemWords) : 1;
  localparam int CntW   = $clog2(RespDepth + 1);
  localparam int PtrW   = (RespDepth > 1) ? $clog2(RespDepth) : 1;
  localparam int DumpW  = (DumpPeriod > 1) ? $clog2(DumpPeriod) : 1;
  localparam logic [AddrW-1:0] OffMask  = AddrW'((1 << OffW) - 1);
  localparam logic [AddrW-1:0] MemLimit = AddrW'(MemWords);

  typedef struct packed {
    logic             err;
    logic [IdW-1:0]   id;
    logic [PortW-1:0] port;
    logic [DataW-1:0] data;
  } ans_t;

  logic [DataW-1:0] mem [MemWords];

  logic [PortW-1:0] rr_last;
  logic [CntW-1:0]  in_flight;
  logic [Latency-1:0] pipe_vld;
  ans_t             pipe_q [Latency];
  ans_t             fifo_q [RespDepth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [CntW-1:0]  fifo_cnt;

  logic             found;
  logic [PortW-1:0] win;
  logic             grant_ok;
  logic             grant;
  logic             pop;
  logic             push;

  logic             sel_we;
  logic [AddrW-1:0] sel_addr;
  logic [DataW-1:0] sel_wdata;
  logic [IdW-1:0]   sel_id;
  logic [AddrW-1:0] word_full;
  logic [IdxW-1:0]  mem_idx;
  logic             acc_err;
  logic [DataW-1:0] rd_word;
  ans_t             new_ans;
  ans_t             head;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] v);
    return (v == PtrW'(RespDepth - 1)) ? '0 : v + 1'b1;
  endfunction

  // Round-robin search: ports above the last winner first, then wrap around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int p = 0; p < NumPorts; p++) begin
      if (!found && req_valid_i[p] && (p > int'(rr_last))) begin
        found = 1'b1;
        win   = PortW'(p);
      end
    end
    for (int p = 0; p < NumPorts; p++) begin
      if (!found && req_valid_i[p] && (p <= int'(rr_last))) begin
        found = 1'b1;
        win   = PortW'(p);
      end
    end
  end

  // Grant needs a free credit. Reset and flush also block it.
  always_comb begin
    grant_ok    = !rst_i && !flush_i && (in_flight < CntW'(RespDepth));
    grant       = found && grant_ok;
    req_ready_o = '0;
    if (grant) req_ready_o[win] = 1'b1;
  end

  // Mux the winning port's request fields.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_id    = '0;
    for (int p = 0; p < NumPorts; p++) begin
      if (win == PortW'(p)) begin
        sel_we    = req_we_i[p];
        sel_addr  = req_addr_i[p*AddrW +: AddrW];
        sel_wdata = req_wdata_i[p*DataW +: DataW];
        sel_id    = req_id_i[p*IdW +: IdW];
      end
    end
  end

  // Decode the address and build the answer word for the granted access.
  always_comb begin
    word_full    = sel_addr >> OffW;
    mem_idx      = word_full[IdxW-1:0];
    acc_err      = ((sel_addr & OffMask) != '0) || (word_full >= MemLimit);
    rd_word      = mem[mem_idx];
    new_ans.err  = acc_err;
    new_ans.id   = sel_id;
    new_ans.port = win;
    if (acc_err)     new_ans.data = '0;
    else if (sel_we) new_ans.data = sel_wdata;
    else             new_ans.data = rd_word;
  end

  // The array is never reset, so the bench can preload it and contents survive reset.
  always_ff @(posedge clk_i) begin
    if (grant && sel_we && !acc_err) mem[mem_idx] <= sel_wdata;
  end

  assign push = pipe_vld[Latency-1] && !flush_i;
  assign pop  = ans_valid_o && ans_ready_i;

  // Payload registers: the valid bits gate them, so they need no reset.
  always_ff @(posedge clk_i) begin
    pipe_q[0] <= new_ans;
    for (int s = 1; s < Latency; s++) pipe_q[s] <= pipe_q[s-1];
    if (push) fifo_q[wr_ptr] <= pipe_q[Latency-1];
  end

  // Control state: arbiter pointer, pipeline valids, FIFO pointers and credits.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_last   <= PortW'(NumPorts - 1);
      pipe_vld  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      in_flight <= '0;
    end else if (flush_i) begin
      pipe_vld  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      in_flight <= '0;
    end else begin
      if (grant) rr_last <= win;
      pipe_vld[0] <= grant;
      for (int s = 1; s < Latency; s++) pipe_vld[s] <= pipe_vld[s-1];
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      case ({grant, pop})
        2'b10:   in_flight <= in_flight + 1'b1;
        2'b01:   in_flight <= in_flight - 1'b1;
        default: in_flight <= in_flight;
      endcase
    end
  end

  // Answer outputs come from the FIFO head and are forced to zero while the FIFO is empty.
  always_comb begin
    head        = fifo_q[rd_ptr];
    ans_valid_o = (fifo_cnt != '0);
    ans_data_o  = ans_valid_o ? head.data : '0;
    ans_port_o  = ans_valid_o ? head.port : '0;
    ans_id_o    = ans_valid_o ? head.id   : '0;
    ans_err_o   = ans_valid_o ? head.err  : 1'b0;
    busy_o      = (in_flight != '0);
  end

  generate
    if (DumpPeriod == 0) begin : g_no_dump
      assign dump_tick_o = 1'b0;
    end else begin : g_dump
      logic [DumpW-1:0] dump_cnt;
      logic             dump_q;
      // Free-running wrap counter. Flush does not touch it.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          dump_cnt <= '0;
          dump_q   <= 1'b0;
        end else if (dump_cnt == DumpW'(DumpPeriod - 1)) begin
          dump_cnt <= '0;
          dump_q   <= 1'b1;
        end else begin
          dump_cnt <= dump_cnt + 1'b1;
          dump_q   <= 1'b0;
        end
      end
      assign dump_tick_o = dump_q;
    end
  endgenerate

endmodule
